// File: rtl/secure_memory_dump_reader_if.sv
// ---------------------------------------------------------------------------
// secure_memory_dump_reader_if
//
// Groups the signals between the dump reader and its surroundings: the
// dump request, the secure-memory read port, the on-chip byte strobe and
// the UART pin with its status flags.
//
// Handshake semantics (the only handshakes on this bus):
//   start      - single-cycle request, no ready. It is honoured only when
//                the reader is idle (busy=0, done=0). At any other time it
//                is dropped and never queued.
//   byte_valid - single-cycle strobe, no backpressure. byte_data is valid
//                while byte_valid is high and is held until the next strobe.
//
// Modports:
//   master - the dump reader (drives the address, strobe, tx and status)
//   slave  - the environment (memory + requester + log sink)
// ---------------------------------------------------------------------------
interface secure_memory_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_value;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_addr, last_addr, mem_value,
    output mem_address, byte_valid, byte_data, tx, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, mem_value,
    input  mem_address, byte_valid, byte_data, tx, busy, done
  );
endinterface

// File: rtl/secure_memory_dump_reader.sv
// ---------------------------------------------------------------------------
// secure_memory_dump_reader
//
// Walks an inclusive address range of a registered-read secure memory,
// captures each returned byte after READ_LATENCY cycles and sends it out
// as an 8N1 UART frame (start 0, DATA_W bits LSB first, stop 1). Each
// captured byte is also presented on a one-cycle parallel strobe.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   bus      - secure_memory_dump_reader_if.master: start/first_addr/
//              last_addr in, mem_address out, mem_value in, byte_valid/
//              byte_data out, tx out, busy out, done out
//   state_o  - current FSM state (debug visibility)
//
// Timing per byte (L = edge that loads mem_address):
//   L+READ_LATENCY      : byte captured, byte_valid high for one cycle
//   L+READ_LATENCY+1    : tx falls (start bit)
//   +(DATA_W+2)*CLKS_PER_BIT : stop bit ends; next address loaded on that
//                         edge, or done pulses and busy drops.
// So consecutive frames are separated by READ_LATENCY+1 idle-high cycles.
// ---------------------------------------------------------------------------
module secure_memory_dump_reader #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  secure_memory_dump_reader_if.master   bus,
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 3);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_DATA_LAST = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_STOP      = BIT_W'(DATA_W + 1);
  // One extra cycle after the stop bit so the stop bit is fully visible on
  // the registered tx pin before the next address/done edge.
  localparam logic [BIT_W-1:0] BIT_TAIL      = BIT_W'(DATA_W + 2);
  localparam logic [3:0]       LAT_LAST      =
    4'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);
  // With a single-cycle memory there is nothing to wait out.
  localparam state_t           AFTER_LOAD    =
    (READ_LATENCY == 1) ? S_CAPTURE : S_WAIT;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   cur_addr_q,  cur_addr_d;
  logic [ADDR_W-1:0]   end_addr_q,  end_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   byte_data_q, byte_data_d;
  logic [DATA_W-1:0]   shift_q,     shift_d;
  logic                byte_valid_q, byte_valid_d;
  logic                tx_q,        tx_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic [3:0]          lat_q,       lat_d;
  logic [CNT_W-1:0]    clk_cnt_q,   clk_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      end_addr_q   <= '0;
      mem_addr_q   <= '0;
      byte_data_q  <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lat_q        <= '0;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      end_addr_q   <= end_addr_d;
      mem_addr_q   <= mem_addr_d;
      byte_data_q  <= byte_data_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lat_q        <= lat_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    end_addr_d   = end_addr_q;
    mem_addr_d   = mem_addr_q;
    byte_data_d  = byte_data_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    tx_d         = 1'b1;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lat_d        = lat_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cur_addr_d = bus.first_addr;
          end_addr_d = bus.last_addr;
          mem_addr_d = bus.first_addr;
          busy_d     = 1'b1;
          lat_d      = '0;
          state_d    = AFTER_LOAD;
        end
      end

      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      S_CAPTURE: begin
        // This edge is exactly READ_LATENCY cycles after mem_address load.
        byte_data_d  = bus.mem_value;
        shift_d      = bus.mem_value;
        byte_valid_d = 1'b1;
        clk_cnt_d    = '0;
        bit_cnt_d    = '0;
        state_d      = S_SEND;
      end

      S_SEND: begin
        // tx is registered, so the pin lags these counters by one cycle.
        if (bit_cnt_q == '0) begin
          tx_d = 1'b0;
        end else if (bit_cnt_q <= BIT_DATA_LAST) begin
          tx_d = shift_q[0];
        end else begin
          tx_d = 1'b1;
        end

        if (bit_cnt_q == BIT_TAIL) begin
          tx_d = 1'b1;
          if (cur_addr_q == end_addr_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            mem_addr_d = cur_addr_q + ADDR_W'(1);
            lat_d      = '0;
            state_d    = AFTER_LOAD;
          end
        end else if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = (bit_cnt_q == BIT_STOP) ? BIT_TAIL : bit_cnt_q + BIT_W'(1);
          if ((bit_cnt_q != '0) && (bit_cnt_q <= BIT_DATA_LAST)) begin
            shift_d = shift_q >> 1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_address = mem_addr_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.byte_data   = byte_data_q;
  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign state_o         = state_q;

endmodule
